// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit path.
//   rx_state_t        receiver FSM states
//   OVERSAMPLE        uart_rx_clk ticks per bit (matches the clock generator)
//   SAMPLE_IDX0       first of the three mid-bit sample indices
//   SAMPLE_IDX_DECIDE index at which the voted bit value is acted on
//   LAST_IDX          final tick index of a bit period
//   DEFAULT_DATA_BITS default frame payload width
//   majority3()       2-of-3 vote used for mid-bit noise rejection
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE        = 16;
  localparam int SAMPLE_IDX0       = 7;
  localparam int SAMPLE_IDX_DECIDE = 9;
  localparam int LAST_IDX          = OVERSAMPLE - 1;
  localparam int DEFAULT_DATA_BITS = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: generic two-flop synchronizer for a single asynchronous bit.
//   clk  input   destination clock
//   rst  input   synchronous, active-high reset; both flops load RESET_VAL
//   d    input   asynchronous input
//   q    output  synchronized copy of d, two clk edges of latency
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with 16x oversampling and mid-bit
// majority voting, presenting bytes on a valid/ready handshake.
//   sys_clk      input   system clock, rising edge
//   sys_rst      input   synchronous, active-high reset
//   uart_rx_clk  input   one-cycle enable at OVERSAMPLE x baud
//   uart_rxd     input   asynchronous serial line, idle high
//   rx_data      output  received byte, stable while rx_valid=1
//   rx_valid     output  byte available, held until accepted
//   rx_ready     input   consumer accepts on rx_valid & rx_ready
//   frame_err    output  one-cycle pulse when the stop bit votes 0
//   overrun_err  output  one-cycle pulse when a byte is dropped because
//                        the previous one is still pending
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rx_clk,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [TW-1:0]  IDX_A      = TW'(SAMPLE_IDX0);
  localparam logic [TW-1:0]  IDX_B      = TW'(SAMPLE_IDX0 + 1);
  localparam logic [TW-1:0]  IDX_DECIDE = TW'(SAMPLE_IDX_DECIDE);
  localparam logic [TW-1:0]  IDX_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [TW-1:0]        tick_idx;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 samp_a;
  logic                 samp_b;
  logic                 rxd_s;

  uart_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(sys_clk),
    .rst(sys_rst),
    .d  (uart_rxd),
    .q  (rxd_s)
  );

  // The third vote is the live synchronized sample at the decide index, so
  // the decision never waits an extra tick.
  logic          vote;
  logic [TW-1:0] next_idx;
  logic          at_decide;
  logic          good_frame;

  assign vote       = majority3(samp_a, samp_b, rxd_s);
  assign next_idx   = (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
  assign at_decide  = uart_rx_clk && (tick_idx == IDX_DECIDE);
  assign good_frame = at_decide && (state == STOP) && vote;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      tick_idx    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      // An accept in the same cycle as a completed frame frees the slot,
      // so the new byte is loaded rather than counted as an overrun.
      if (good_frame) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (uart_rx_clk) begin
        if (tick_idx == IDX_A) samp_a <= rxd_s;
        if (tick_idx == IDX_B) samp_b <= rxd_s;

        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state    <= START;
              tick_idx <= TW'(1);
            end else begin
              tick_idx <= '0;
            end
          end

          START: begin
            tick_idx <= next_idx;
            if (tick_idx == IDX_DECIDE && vote) begin
              state    <= IDLE;
              tick_idx <= '0;
            end else if (tick_idx == IDX_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end

          DATA: begin
            tick_idx <= next_idx;
            if (tick_idx == IDX_DECIDE) begin
              shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            end
            if (tick_idx == IDX_LAST) begin
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          // Leaving at mid-stop gives half a bit of slack to catch the
          // next start edge when the sender runs slightly fast.
          STOP: begin
            tick_idx <= next_idx;
            if (tick_idx == IDX_DECIDE) begin
              tick_idx <= '0;
              if (vote) begin
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end
          end

          // A line held low after a framing error is a break, not a stream
          // of zero bytes; wait for it to return high.
          BREAK: begin
            tick_idx <= '0;
            if (rxd_s) state <= IDLE;
          end

          default: begin
            state    <= IDLE;
            tick_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard testbench for uart_rx. Stimulus tasks push the
// expected events (bytes, frame errors, overruns) into a queue; an
// independent monitor pops and compares whenever the DUT presents one.
module tb_uart_rx;

  localparam int BIT_CYCLES = 434;
  localparam int TICK_DIV   = 27;
  localparam int FRAME_BITS = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rx_clk;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;

  int checks      = 0;
  int failures    = 0;
  int valid_count = 0;
  int div_cnt     = 0;

  typedef enum {EV_BYTE, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];

  uart_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_rx_clk(uart_rx_clk),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #10 sys_clk = ~sys_clk;

  // Stands in for uart_clk_gen(50 MHz, 115200): a one-cycle tick every 27 cycles.
  always @(posedge sys_clk) div_cnt <= (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
  assign uart_rx_clk = (div_cnt == TICK_DIV - 1);

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%02h required=0x%02h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic scoreboardPop(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected event: actual=%s 0x%02h required=none", kind.name(), data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_BYTE && e.data !== data)) begin
        failures++;
        $display("[TB] FAIL scoreboard: actual=%s 0x%02h required=%s 0x%02h",
                 kind.name(), data, e.kind.name(), e.data);
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic driveLevel(input logic level, input int n);
    repeat (n) begin
      @(negedge sys_clk);
      uart_rxd = level;
    end
  endtask

  // Drives one frame. With align set, the start bit is applied in the cycle
  // of a tick, so the receiver's start-detect tick lands at cycle 27 and its
  // sample index k of bit j is taken from the value driven at cycle
  // 25 + 432*j + 27*k (two flops of synchronizer delay). Index 8 is then at
  // 241 + 432*j; the glitch covers +/-13 cycles around it, missing 7 and 9.
  // reset_at >= 0 pulses sys_rst at that frame cycle and checks outputs next cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input bit align,
                               input bit glitch, input int reset_at);
    if (align) begin
      @(negedge sys_clk);
      while (!uart_rx_clk) @(negedge sys_clk);
    end
    for (int c = 0; c < FRAME_BITS * BIT_CYCLES; c++) begin
      int   j;
      logic v;
      if (c != 0 || !align) @(negedge sys_clk);
      j = c / BIT_CYCLES;
      if (j == 0)      v = 1'b0;
      else if (j <= 8) v = data[j-1];
      else             v = stop_val;
      if (glitch && j >= 1 && j <= 8 && c >= 228 + 432 * j && c <= 254 + 432 * j) v = ~v;
      uart_rxd = v;
      sys_rst  = (c == reset_at);
      if (reset_at >= 0 && c == reset_at + 1) begin
        checkOutput("reset mid-frame rx_valid", 8'(rx_valid), 8'h00);
        checkOutput("reset mid-frame rx_data", rx_data, 8'h00);
        checkOutput("reset mid-frame frame_err", 8'(frame_err), 8'h00);
        checkOutput("reset mid-frame overrun_err", 8'(overrun_err), 8'h00);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge. A byte is new when
  // rx_valid is high and the previous cycle either had no valid byte or
  // completed a handshake; otherwise a held byte must not change.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always begin
    @(posedge sys_clk);
    #1;
    if (frame_err === 1'b1)   scoreboardPop(EV_FERR, 8'h00);
    if (overrun_err === 1'b1) scoreboardPop(EV_OVR, 8'h00);
    if (rx_valid === 1'b1) begin
      valid_count++;
      if (!prev_valid || prev_ready) scoreboardPop(EV_BYTE, rx_data);
      else                           checkOutput("rx_data held", rx_data, prev_data);
    end
    prev_valid = (rx_valid === 1'b1);
    prev_ready = rx_ready;
    prev_data  = rx_data;
  end

  initial begin
    #(20 * 95000);
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    waitCycles(5);
    sys_rst = 1'b0;
    waitCycles(1);
    checkOutput("reset rx_valid", 8'(rx_valid), 8'h00);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset frame_err", 8'(frame_err), 8'h00);
    checkOutput("reset overrun_err", 8'(overrun_err), 8'h00);
    waitCycles(BIT_CYCLES);

    $display("[TB] test 1: 0xA5 with rx_ready=1");
    valid_count = 0;
    pushExpected(EV_BYTE, 8'hA5);
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, -1);
    waitCycles(200);
    checkOutput("t1 rx_valid width", 8'(valid_count), 8'd1);
    checkOutput("t1 rx_data", rx_data, 8'hA5);

    $display("[TB] test 2: 0x00 then 0xFF with rx_ready=0");
    rx_ready = 1'b0;
    pushExpected(EV_BYTE, 8'h00);
    pushExpected(EV_OVR, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, -1);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, -1);
    waitCycles(200);
    checkOutput("t2 rx_valid held", 8'(rx_valid), 8'h01);
    checkOutput("t2 rx_data kept", rx_data, 8'h00);
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
    checkOutput("t2 rx_valid after accept", 8'(rx_valid), 8'h00);
    rx_ready = 1'b1;

    $display("[TB] test 3: 3-tick low glitch");
    driveLevel(1'b0, 3 * TICK_DIV);
    driveLevel(1'b1, 2 * BIT_CYCLES);
    checkOutput("t3 rx_valid", 8'(rx_valid), 8'h00);

    $display("[TB] test 4: bad stop, break, then 0x55");
    pushExpected(EV_FERR, 8'h00);
    pushExpected(EV_BYTE, 8'h55);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0, -1);
    driveLevel(1'b0, 20 * BIT_CYCLES);
    driveLevel(1'b1, 2 * BIT_CYCLES);
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b0, -1);
    waitCycles(200);
    checkOutput("t4 rx_data", rx_data, 8'h55);

    $display("[TB] test 5: 0x81 with index-8 glitches, left pending");
    rx_ready = 1'b0;
    pushExpected(EV_BYTE, 8'h81);
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1, -1);
    waitCycles(200);
    checkOutput("t5 rx_data", rx_data, 8'h81);
    checkOutput("t5 rx_valid", 8'(rx_valid), 8'h01);

    // Reset late in data bit 7 (value 0) so the remaining low stretch is
    // too short to survive the false-start check.
    $display("[TB] test 6: reset during 0x6E, then 0x12");
    applyStimulus(8'h6E, 1'b1, 1'b1, 1'b0, 8 * BIT_CYCLES + 380);
    driveLevel(1'b1, 2 * BIT_CYCLES);
    checkOutput("t6 no output after reset", 8'(rx_valid), 8'h00);
    rx_ready = 1'b1;
    pushExpected(EV_BYTE, 8'h12);
    applyStimulus(8'h12, 1'b1, 1'b1, 1'b0, -1);
    waitCycles(200);
    checkOutput("t6 rx_data", rx_data, 8'h12);

    waitCycles(BIT_CYCLES);
    checkOutput("scoreboard drained", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
